inv_sub_bytes_engine: RTL and testbench

Iterative AES-256 decryption stage that performs InvShiftRows (optional, per transaction) followed by InvSubBytes on a 128-bit state.
- Instantiates LANES copies of the 8-bit InverseSbox and time-multiplexes them over the 16 state bytes.
- Sits between the round-key XOR / InvMixColumns path and the decryption round controller.
- Uses valid/ready handshakes on both sides.

---
 rtl/aes_dec_pkg.sv | 31 +++
 rtl/aes_inv_sbox.sv | 29 ++
 rtl/inv_sub_bytes_engine.sv | 122 ++++++++++++
 tb/tb_inv_sub_bytes_engine.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/aes_dec_pkg.sv
// Shared AES decryption types and helpers: byte/state layout and InvShiftRows.
// State byte k is row k%4, column k/4 and sits at bits [127-8k -: 8].
package aes_dec_pkg;

  localparam int NB_BYTES = 16;

  typedef logic [7:0] byte_t;
  typedef logic [0:NB_BYTES-1][7:0] state_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fsm_t;

  function automatic int byte_idx(input int r, input int c);
    return r + 4 * c;
  endfunction

  // Row r rotates right by r columns: out[r][c] = in[r][(c-r) mod 4].
  function automatic state_t inv_shift_rows(input state_t s);
    state_t o;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[byte_idx(r, c)] = s[byte_idx(r, (c - r + 4) % 4)];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// AES inverse S-box: purely combinational 256-entry byte lookup.
module aes_inv_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  // Entry x occupies bits [2047-8x -: 8].
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  assign out_byte = INV_SBOX[{8'hff - in_byte, 3'b000} +: 8];

endmodule

// File: rtl/inv_sub_bytes_engine.sv
// Iterative InvShiftRows + InvSubBytes engine: LANES inverse S-boxes are
// time-multiplexed over the 16 state bytes, with valid/ready on both sides.
module inv_sub_bytes_engine
  import aes_dec_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_shift,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int NGROUPS = NB_BYTES / LANES;
  localparam int CW = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
  localparam logic [CW-1:0] LAST_GRP = CW'(NGROUPS - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("inv_sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
  end

  fsm_t            state_r;
  logic [CW-1:0]   cnt_r;
  state_t          buf_r;
  logic [127:0]    out_state_r;
  logic            out_valid_r;
  logic            busy_r;

  byte_t [LANES-1:0] lane_in_s;
  byte_t [LANES-1:0] lane_out_s;
  state_t            next_buf_s;
  state_t            load_s;
  logic              accept_s;

  function automatic logic [3:0] lane_pos(input logic [CW-1:0] grp, input int lane);
    return 4'(int'(grp) * LANES + lane);
  endfunction

  assign in_ready  = (state_r == ST_IDLE) | ((state_r == ST_DONE) & out_ready);
  assign accept_s  = in_valid & in_ready;
  assign load_s    = in_shift ? inv_shift_rows(state_t'(in_state)) : state_t'(in_state);
  assign out_valid = out_valid_r;
  assign out_state = out_state_r;
  assign busy      = busy_r;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    aes_inv_sbox u_sbox (
      .in_byte  (lane_in_s[l]),
      .out_byte (lane_out_s[l])
    );
  end

  // Select the current byte group from the working buffer.
  always_comb begin
    lane_in_s = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_in_s[l] = buf_r[lane_pos(cnt_r, l)];
    end
  end

  // Write the substituted group back in place.
  always_comb begin
    next_buf_s = buf_r;
    for (int l = 0; l < LANES; l++) begin
      next_buf_s[lane_pos(cnt_r, l)] = lane_out_s[l];
    end
  end

  // Control FSM, working buffer and registered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      buf_r       <= '0;
      out_state_r <= 128'd0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else if (accept_s) begin
      // A DONE-state accept also retires the previous result on this edge.
      buf_r       <= load_s;
      cnt_r       <= '0;
      state_r     <= ST_RUN;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b1;
    end else begin
      case (state_r)
        ST_RUN: begin
          buf_r <= next_buf_s;
          if (cnt_r == LAST_GRP) begin
            state_r     <= ST_DONE;
            out_state_r <= next_buf_s;
            out_valid_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
          end
        end
        ST_IDLE: begin
          busy_r <= 1'b0;
        end
        default: begin
          state_r     <= ST_IDLE;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inv_sub_bytes_engine.sv
// Scoreboard bench for inv_sub_bytes_engine at LANES = 4, 1 and 16.
`timescale 1ns/1ps
module tb_inv_sub_bytes_engine;

  localparam logic [127:0] V_ZERO  = 128'h0;
  localparam logic [127:0] V_INC   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] V_63    = {16{8'h63}};
  localparam logic [127:0] E_ZERO  = {16{8'h52}};
  localparam logic [127:0] E_INC   = 128'h52096ad53036a538bf40a39e81f3d7fb;
  localparam logic [127:0] E_INCSH = 128'h52f3a3383009d79ebf366afb8140a5d5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         iv   [3];
  logic [127:0] ist  [3];
  logic         ish  [3];
  logic         ordy [3];
  logic         irdy [3];
  logic         ov   [3];
  logic [127:0] ost  [3];
  logic         bsy  [3];
  logic         prev_ov [3];
  int           lat_of [3];

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [127:0] exp_q0[$], exp_q1[$], exp_q2[$];
  int           rise_q0[$], rise_q1[$], rise_q2[$];

  inv_sub_bytes_engine #(.LANES(4)) u_l4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(irdy[0]), .in_state(ist[0]),
    .in_shift(ish[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_state(ost[0]), .busy(bsy[0]));
  inv_sub_bytes_engine #(.LANES(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(irdy[1]), .in_state(ist[1]),
    .in_shift(ish[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_state(ost[1]), .busy(bsy[1]));
  inv_sub_bytes_engine #(.LANES(16)) u_l16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(irdy[2]), .in_state(ist[2]),
    .in_shift(ish[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_state(ost[2]), .busy(bsy[2]));

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input int d, input logic [127:0] s, input int r);
    case (d)
      0: begin exp_q0.push_back(s); rise_q0.push_back(r); end
      1: begin exp_q1.push_back(s); rise_q1.push_back(r); end
      default: begin exp_q2.push_back(s); rise_q2.push_back(r); end
    endcase
  endtask

  function automatic int pending(input int d);
    case (d)
      0: return exp_q0.size() + rise_q0.size();
      1: return exp_q1.size() + rise_q1.size();
      default: return exp_q2.size() + rise_q2.size();
    endcase
  endfunction

  task automatic check_rise(input int d);
    int r;
    if (d == 0 && rise_q0.size() > 0) r = rise_q0.pop_front();
    else if (d == 1 && rise_q1.size() > 0) r = rise_q1.pop_front();
    else if (d == 2 && rise_q2.size() > 0) r = rise_q2.pop_front();
    else r = -1;
    chk($sformatf("latency[%0d]", d), 128'(cyc), 128'(r));
  endtask

  task automatic check_out(input int d);
    logic [127:0] e;
    if (d == 0 && exp_q0.size() > 0) e = exp_q0.pop_front();
    else if (d == 1 && exp_q1.size() > 0) e = exp_q1.pop_front();
    else if (d == 2 && exp_q2.size() > 0) e = exp_q2.pop_front();
    else e = 128'hx;
    chk($sformatf("out_state[%0d]", d), ost[d], e);
  endtask

  // Monitor: samples mid-low-phase, after stimulus has settled for the coming edge.
  always @(negedge clk) begin
    #2;
    for (int d = 0; d < 3; d++) begin
      if (rst_n && ov[d] && !prev_ov[d]) check_rise(d);
      if (rst_n && ov[d] && ordy[d]) check_out(d);
      prev_ov[d] = ov[d];
    end
  end

  // Called at a falling edge; returns at the falling edge after the accept edge.
  task automatic send(input int d, input logic [127:0] s, input logic sh, input logic [127:0] e);
    int budget = 0;
    iv[d] = 1'b1; ist[d] = s; ish[d] = sh;
    #1;
    while (!irdy[d] && budget < 200) begin
      @(negedge clk); #1; budget++;
    end
    if (!irdy[d]) begin
      n_vec++; n_bad++;
      $display("FAIL accept_timeout[%0d]: in_ready stayed 0", d);
    end else begin
      push_exp(d, e, cyc + 1 + lat_of[d]);
    end
    @(negedge clk);
    iv[d] = 1'b0;
  endtask

  task automatic drain(input int d);
    int budget = 0;
    while (pending(d) != 0 && budget < 100) begin
      @(negedge clk); budget++;
    end
    if (pending(d) != 0) begin
      n_vec++; n_bad++;
      $display("FAIL drain_timeout[%0d]: %0d entries left, want 0", d, pending(d));
    end
  endtask

  initial begin
    lat_of[0] = 4; lat_of[1] = 16; lat_of[2] = 1;
    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0; ist[d] = 128'h0; ish[d] = 1'b0; ordy[d] = 1'b1; prev_ov[d] = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_in_ready[%0d]", d), 128'(irdy[d]), 128'd1);
      chk($sformatf("rst_out_valid[%0d]", d), 128'(ov[d]), 128'd0);
      chk($sformatf("rst_busy[%0d]", d), 128'(bsy[d]), 128'd0);
    end
    chk("rst_out_state", ost[0], 128'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // LANES=4 basic vectors, streamed back to back.
    send(0, V_ZERO, 1'b0, E_ZERO);
    send(0, V_INC, 1'b0, E_INC);
    send(0, V_INC, 1'b1, E_INCSH);
    drain(0);

    // Result held while downstream stalls, then handoff + accept on one edge.
    @(negedge clk);
    ordy[0] = 1'b0;
    send(0, V_INC, 1'b0, E_INC);
    for (int b = 0; b < 20 && !ov[0]; b++) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("hold_out_valid", 128'(ov[0]), 128'd1);
      chk("hold_out_state", ost[0], E_INC);
      chk("hold_in_ready", 128'(irdy[0]), 128'd0);
      @(negedge clk);
    end
    ordy[0] = 1'b1;
    send(0, V_ZERO, 1'b1, E_ZERO);
    drain(0);

    // Asynchronous reset in the middle of RUN discards the transaction.
    @(negedge clk);
    send(0, V_INC, 1'b0, E_INC);
    @(negedge clk); @(negedge clk);
    chk("mid_run_busy", 128'(bsy[0]), 128'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 128'(ov[0]), 128'd0);
    chk("arst_out_state", ost[0], 128'h0);
    chk("arst_busy", 128'(bsy[0]), 128'd0);
    chk("arst_in_ready", 128'(irdy[0]), 128'd1);
    exp_q0.delete(); rise_q0.delete();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(0, V_63, 1'b0, 128'h0);
    drain(0);

    // Same vectors on the 1-lane and 16-lane builds.
    for (int d = 1; d < 3; d++) begin
      send(d, V_ZERO, 1'b0, E_ZERO);
      send(d, V_INC, 1'b0, E_INC);
      drain(d);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
